// File: rtl/dmem_port_arbiter.sv
// Two-lane to single-port data memory arbiter: lane 1 first, one-cycle stall on conflict.
// Optional DMEM_ARB_STATS_EN adds saturating conflict/access counters.
module dmem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req1_cs,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic [DW-1:0] req1_rdata,
  input  logic          req2_cs,
  input  logic          req2_we,
  input  logic [AW-1:0] req2_addr,
  input  logic [DW-1:0] req2_wdata,
  output logic [DW-1:0] req2_rdata,
  output logic          stall,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt,
  output logic [15:0]   access_cnt
`endif
);

  typedef enum logic {SINGLE = 1'b0, SECOND = 1'b1} state_t;

  state_t        state;
  logic [DW-1:0] hold_rdata1;
  logic          pend2_we;
  logic [AW-1:0] pend2_addr;
  logic [DW-1:0] pend2_wdata;
  logic          conflict;

  // Kept free of address/data so the stall path stays short.
  assign conflict = (state == SINGLE) && req1_cs && req2_cs;
  assign stall    = conflict;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= SINGLE;
      hold_rdata1 <= '0;
      pend2_we    <= 1'b0;
      pend2_addr  <= '0;
      pend2_wdata <= '0;
    end else begin
      case (state)
        SINGLE: if (conflict) begin
          state       <= SECOND;
          hold_rdata1 <= mem_rdata;
          pend2_we    <= req2_we;
          pend2_addr  <= req2_addr;
          pend2_wdata <= req2_wdata;
        end
        SECOND: state <= SINGLE;
        default: state <= SINGLE;
      endcase
    end
  end

  always_comb begin
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = req1_addr;
    mem_wdata  = req1_wdata;
    req1_rdata = mem_rdata;
    req2_rdata = mem_rdata;
    if (state == SECOND) begin
      // A reset landing here drops the pending lane 2 access outright.
      mem_cs     = !RST;
      mem_we     = pend2_we && !RST;
      mem_addr   = pend2_addr;
      mem_wdata  = pend2_wdata;
      req1_rdata = hold_rdata1;
    end else if (req1_cs) begin
      mem_cs     = 1'b1;
      mem_we     = req1_we;
    end else if (req2_cs) begin
      mem_cs     = 1'b1;
      mem_we     = req2_we;
      mem_addr   = req2_addr;
      mem_wdata  = req2_wdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      conflict_cnt <= '0;
      access_cnt   <= '0;
    end else begin
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      if (mem_cs && access_cnt != 16'hFFFF)     access_cnt   <= access_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Schedules the two memory-access lanes of the dual-issue pipeline onto one single-ported data memory. Sits between the MA-stage lane signals (chip-select, read/write, address, store data) and the data RAM. It serves lane 1 before lane 2 in program order, and stalls the pipeline for exactly one cycle when both lanes access memory in the same cycle.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `RST`  in  1  reset, synchronous, active-high; sampled on the rising edge of `CLK`
- `req1_cs`, `req2_cs`  in  1  lane memory access valid
- `req1_we`, `req2_we`  in  1  1 = store, 0 = load
- `req1_addr`, `req2_addr`  in  AW  byte address, forwarded unmodified
- `req1_wdata`, `req2_wdata`  in  DW  store data
- `req1_rdata`, `req2_rdata`  out  DW  load data returned to the lane
- `stall`  out  1  pipeline hold; freezes all stage registers at the next edge
- `mem_cs`  out  1  memory chip-select
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, combinational from `mem_addr` in the same cycle

## Operation
- FSM with two states: `SINGLE` (reset state) and `SECOND`.
- `SINGLE`, at most one `reqN_cs` high:
  - Pass that lane through combinationally to `mem_*`.
  - `reqN_rdata` = `mem_rdata`.
  - `stall` = 0.
  - Stay in `SINGLE`.
- `SINGLE`, neither lane requests:
  - `mem_cs` = 0, `mem_we` = 0.
  - Address and data are don't-care but driven from lane 1.
- `SINGLE`, both `cs` high (conflict):
  - Issue lane 1 to memory this cycle.
  - `stall` = 1.
  - At the edge: capture `mem_rdata` into `hold_rdata1`, latch lane 2 `we`/`addr`/`wdata` into `pend2_*`, go to `SECOND`.
- `SECOND`:
  - Issue the latched `pend2_*` request. Never re-issue lane 1, even though its held inputs are still asserted; a store is never written twice.
  - `req1_rdata` = `hold_rdata1`; `req2_rdata` = `mem_rdata`.
  - `stall` = 0.
  - Return to `SINGLE` at the edge.
- Ordering: lane 1 always precedes lane 2.
  - Lane 1 store / lane 2 load to the same address: the load returns the new data.
  - Lane 1 load / lane 2 store to the same address: the load returns the old data.
- `reqN_rdata` is only meaningful for a load on lane N. Otherwise drive it with the current selected value; no gating required.
- The `stall` path depends only on the FSM state and `req1_cs`/`req2_cs`. It never depends on `mem_rdata` or the address inputs.

## Timing
- Reset (`RST` high at an edge):
  - State goes to `SINGLE`; `hold_rdata1` = 0; `pend2_*` = 0.
  - All outputs then follow the `SINGLE` rules. With `cs` low: `stall` = 0, `mem_cs` = 0, `mem_we` = 0.
- `RST` asserted while in `SECOND`: the pending lane 2 access is dropped and no memory write occurs in the following cycle.
- Latency:
  - Non-conflicting access: 0 extra cycles.
  - Conflict: exactly 1 stall cycle. Lane 1 is served in cycle N, lane 2 in cycle N+1, and both lanes' load data are valid in cycle N+1.
- Back-to-back conflicts, i.e. both `cs` high again in the cycle after `SECOND`: start a new conflict sequence. Each conflict stalls 1 cycle; throughput is 2 accesses per 2 cycles.
- In `SECOND`, lane inputs are ignored for issue, since they are held by `stall` and identical to the previous cycle.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - Add output `conflict_cnt` [15:0]: +1 on each transition `SINGLE`→`SECOND`.
  - Add output `access_cnt` [15:0]: +1 each cycle `mem_cs` = 1.
  - Both counters saturate at 16'hFFFF and reset to 0 on `RST`.
- Not defined: both ports and counters are absent. Core behaviour is identical.

## Test plan
- Single lane 1 store, then load: store `addr`=0x10, `wdata`=0xDEADBEEF, then load 0x10 → `stall` stays 0; `req1_rdata`=0xDEADBEEF in the load cycle.
- Conflict, lane 1 store / lane 2 load, same address 0x20, `wdata`=0x12345678 → `stall`=1 for one cycle; the memory write happens exactly once; `req2_rdata`=0x12345678 in cycle N+1.
- Conflict, lane 1 load 0x30 (old 0xAAAA0000) / lane 2 store 0x30 with 0x5555 → `req1_rdata`=0xAAAA0000 in cycle N+1; a later read of 0x30 returns 0x5555.
- Three consecutive conflict pairs → `stall` pattern 1,0,1,0,1,0; six memory accesses in order L1,L2,L1,L2,L1,L2; with the macro defined, `conflict_cnt`=3 and `access_cnt`=6.
- `RST` pulsed in `SECOND` after lane 1 load / lane 2 store conflict → no write to the lane 2 address; next cycle `stall`=0 and `mem_cs` follows the inputs.
- Lane 2 only, load 0x40 → passes through with 0 stall; `req2_rdata`=`mem_rdata`, and `mem_addr`=0x40 in the same cycle.
